serial_tx_framed: RTL and testbench
===================================

# serial_tx_framed

Parametrised, framed serial transmitter; the next generation of the team's 7-bit serial data transmitter. It generalises data width, bit period and stop-bit count, adds an optional parity bit, and adds `busy`/`done` status so a producer can pace frames. It sits between a parallel data source and a single-wire serial link; output idles high, and frames are start bit, LSB-first data, optional parity, then stop bits.

## Interface
Parameters:
- `DATA_W`, 7: data bits per frame (1..32).
- `CLKS_PER_BIT`, 1: clock cycles each serial bit is held (>= 1).
- `STOP_BITS`, 1: number of stop bits (1 or 2).
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Used only when parity is compiled in.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  DATA_W  parallel word; sampled only at frame start.
- `start_transmit`  in  1  level request; sampled only in IDLE.
- `serial_out`  out  1  registered serial line; idles high.
- `busy`  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- `done`  out  1  one-cycle pulse in the final cycle of the last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `serial_out`=1, `busy`=0. Edge with `start_transmit`=1 -> latch `in_data` into shift register, compute parity, enter START.
- START: `serial_out`=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: shift register bit 0 out, shift right every CLKS_PER_BIT cycles. After DATA_W bits -> PARITY if compiled in, else STOP.
- PARITY: `serial_out` = XOR of latched data (even), inverted when PARITY_ODD=1. Held for one bit period -> STOP.
- STOP: `serial_out`=1 for STOP_BITS*CLKS_PER_BIT cycles; `done`=1 in the final cycle -> IDLE.
- `in_data` changes during a frame have no effect on that frame.
- `start_transmit` outside IDLE is ignored: not queued, not latched.
- Level held high: a new frame starts on the first IDLE edge, giving exactly one idle-high cycle between frames.
- Bit-period counter: width $clog2(CLKS_PER_BIT+1); resets to 0 at every bit boundary; no wrap inside a bit.
- Data-bit counter: width $clog2(DATA_W+1); cleared on entry to DATA.

## Timing
- Reset values: `serial_out`=1, `busy`=0, `done`=0, state IDLE, counters 0, shift register 0.
- `rst` has priority over all other inputs. Asserting it mid-frame aborts the frame: one edge later the line is high, `busy` and `done` are 0, and no pulse is emitted.
- Latency: request sampled at edge N -> `serial_out`=0 and `busy`=1 visible after edge N.
- Frame length = CLKS_PER_BIT*(1 + DATA_W + P + STOP_BITS) cycles, where P = 1 with parity compiled in and 0 without.
- `done` is coincident with the last stop-bit cycle; `busy` falls on the following edge.

## Configuration
- `SERIAL_TX_PARITY_EN` defined: the PARITY state and parity logic are present, and each frame carries a parity bit after the data.
- `SERIAL_TX_PARITY_EN` undefined: the PARITY state and logic are absent, DATA goes directly to STOP, `PARITY_ODD` is ignored, and the frame is one bit shorter.

## Structure
- Package `serial_tx_pkg` holds:
  - the state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants `PAR_EVEN`=0 and `PAR_ODD`=1.
- One sub-module, `bit_tick_gen`: a CLKS_PER_BIT period counter with synchronous clear that outputs a one-cycle `bit_tick` at each bit boundary. When CLKS_PER_BIT=1, `bit_tick` is constant 1.

## Test plan
- Reset idle: `rst`=1 for 2 cycles, then start=0 for 5 cycles -> `serial_out`=1, `busy`=0 and `done`=0 throughout.
- Basic frame (DATA_W=7, CLKS_PER_BIT=1, parity on, even): `in_data`=7'b0010011, start pulse -> `serial_out` = 0,1,1,0,0,1,0,0,1(parity),1; `done` in the 10th cycle; `busy` high for 10 cycles.
- Data change mid-frame: same start, then `in_data`=7'b1111110 at bit 3 -> transmitted bits unchanged from 7'b0010011.
- Start while busy: start pulse during DATA -> ignored, exactly one frame is sent. Start held high continuously -> frames separated by exactly one idle-high cycle.
- Bit period and stops (CLKS_PER_BIT=4, STOP_BITS=2, PARITY_ODD=1): `in_data`=7'h55 -> each bit held 4 cycles, parity bit 1, 8 stop cycles, frame length 44 cycles.
- Reset mid-frame: `rst` asserted during DATA bit 4 -> next edge `serial_out`=1 and `busy`=0 with no `done` pulse; a fresh start afterwards sends a complete, correct frame.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// serial_tx_pkg
// Shared types and constants for the framed serial transmitter.
//   tx_state_t : transmitter FSM states (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN   : PARITY_ODD value selecting even parity
//   PAR_ODD    : PARITY_ODD value selecting odd parity
// The PARITY state exists in the enum in every build. It is only reachable
// when the top is compiled with SERIAL_TX_PARITY_EN.
// ---------------------------------------------------------------------------
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_tx_framed_tick.sv
// ---------------------------------------------------------------------------
// bit_tick_gen
// Bit-period counter for the framed serial transmitter. It counts
// CLKS_PER_BIT clock cycles per serial bit. bit_tick is high in the last
// cycle of each bit period.
// Ports:
//   clk      in  1  clock, rising edge
//   rst      in  1  synchronous active-high reset
//   clear    in  1  synchronous clear; holds the count at 0 (used while idle)
//   bit_tick out 1  one-cycle pulse at each bit boundary (constant 1 when
//                   CLKS_PER_BIT == 1)
// ---------------------------------------------------------------------------
module bit_tick_gen
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // The count returns to 0 at every bit boundary and never wraps inside a
  // bit. A clear restarts the period, so the first bit of a frame gets a full
  // period.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // With a single-cycle bit period every cycle is a boundary.
  assign bit_tick = (CLKS_PER_BIT == 1) ? 1'b1 : (cnt == LAST);

endmodule

// File: rtl/serial_tx_framed.sv
// ---------------------------------------------------------------------------
// serial_tx_framed
// Framed serial transmitter. A frame is a start bit (0), DATA_W data bits
// sent LSB first, an optional parity bit, and STOP_BITS stop bits (1).
// The line idles high.
// Optional feature: define SERIAL_TX_PARITY_EN to add the PARITY state and a
// parity bit after the data. PARITY_ODD selects even (0) or odd (1) parity.
// Parameters: DATA_W (1..32), CLKS_PER_BIT (>=1), STOP_BITS (1|2),
//             PARITY_ODD (0|1)
// Ports:
//   clk            in  1       clock, rising edge
//   rst            in  1       synchronous active-high reset, highest priority
//   in_data        in  DATA_W  parallel word, latched only at frame start
//   start_transmit in  1       level request, sampled only in IDLE
//   serial_out     out 1       registered serial line
//   busy           out 1       high for every cycle of a frame
//   done           out 1       pulse in the final cycle of the last stop bit
// ---------------------------------------------------------------------------
module serial_tx_framed
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 7,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              start_transmit,
  output logic              serial_out,
  output logic              busy,
  output logic              done
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_W - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

  // Stop configuration with an illegal parameter value at elaboration.
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
    $error("serial_tx_framed: DATA_W must be 1..32");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_period
    $error("serial_tx_framed: CLKS_PER_BIT must be >= 1");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("serial_tx_framed: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 32'(PAR_EVEN) && PARITY_ODD != 32'(PAR_ODD)) begin : g_bad_par
    $error("serial_tx_framed: PARITY_ODD must be 0 or 1");
  end

  tx_state_t   state, state_nxt;
  logic [DATA_W-1:0] shift_reg, shift_nxt;
  logic [BCW-1:0]    bit_cnt, bit_cnt_nxt;
  logic              stop_cnt, stop_cnt_nxt;
  logic              line_nxt;
  logic              bit_tick;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_bit, parity_nxt;
`endif

  // The bit timer runs only inside a frame. Holding it cleared in IDLE
  // means the start bit always gets a full period.
  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .bit_tick(bit_tick)
  );

  // State and datapath registers. serial_out is registered from the value
  // that belongs to the next state. The line therefore changes on the same
  // edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      serial_out <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      stop_cnt   <= stop_cnt_nxt;
      serial_out <= line_nxt;
`ifdef SERIAL_TX_PARITY_EN
      parity_bit <= parity_nxt;
`endif
    end
  end

  // Next-state and next-line logic. Every state advances only on bit_tick,
  // so each bit is held for a full CLKS_PER_BIT period.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_reg;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    line_nxt     = serial_out;
`ifdef SERIAL_TX_PARITY_EN
    parity_nxt   = parity_bit;
`endif

    case (state)
      IDLE: begin
        line_nxt = 1'b1;
        if (start_transmit) begin
          shift_nxt = in_data;
`ifdef SERIAL_TX_PARITY_EN
          parity_nxt = (^in_data) ^ 1'(PARITY_ODD);
`endif
          state_nxt = START;
          line_nxt  = 1'b0;
        end
      end

      START: begin
        if (bit_tick) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          line_nxt    = shift_reg[0];
        end
      end

      DATA: begin
        if (bit_tick) begin
          if (bit_cnt == LAST_DATA) begin
            stop_cnt_nxt = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            state_nxt = PARITY;
            line_nxt  = parity_bit;
`else
            state_nxt = STOP;
            line_nxt  = 1'b1;
`endif
          end else begin
            shift_nxt   = shift_reg >> 1;
            bit_cnt_nxt = bit_cnt + BCW'(1);
            line_nxt    = shift_nxt[0];
          end
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_nxt    = STOP;
          stop_cnt_nxt = 1'b0;
          line_nxt     = 1'b1;
        end
      end
`endif

      STOP: begin
        line_nxt = 1'b1;
        if (bit_tick) begin
          if (stop_cnt == LAST_STOP) begin
            state_nxt = IDLE;
          end else begin
            stop_cnt_nxt = stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        line_nxt  = 1'b1;
      end
    endcase
  end

  // Both status outputs decode registered state. After a reset edge they
  // are immediately inactive.
  assign busy = (state != IDLE);
  assign done = (state == STOP) && bit_tick && (stop_cnt == LAST_STOP);

endmodule

// File: tb/tb_serial_tx_framed.sv
// ---------------------------------------------------------------------------
// tb_serial_tx_framed
// Directed bench for serial_tx_framed. Instance 0 uses the default
// parameters: 7 data bits, 1 clock per bit, 1 stop bit, even parity.
// Instance 1 uses 7 data bits, 4 clocks per bit, 2 stop bits, odd parity.
// It expects a parity bit when SERIAL_TX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_tx_framed;

`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk;
  logic       rst0, rst1;
  logic [6:0] in_data0, in_data1;
  logic       start0, start1;
  logic       so0, so1, busy0, busy1, done0, done1;

  int tests_run = 0;
  int tests_failed = 0;

  serial_tx_framed dut0 (
    .clk           (clk),
    .rst           (rst0),
    .in_data       (in_data0),
    .start_transmit(start0),
    .serial_out    (so0),
    .busy          (busy0),
    .done          (done0)
  );

  serial_tx_framed #(
    .DATA_W      (7),
    .CLKS_PER_BIT(4),
    .STOP_BITS   (2),
    .PARITY_ODD  (1)
  ) dut1 (
    .clk           (clk),
    .rst           (rst1),
    .in_data       (in_data1),
    .start_transmit(start1),
    .serial_out    (so1),
    .busy          (busy1),
    .done          (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each record holds one data word and its hand-computed even parity.
  typedef struct {
    logic [6:0] data;
    logic       par_even;
  } vec_t;

  vec_t vecs [6];

  task automatic applyStimulus(input int which, input logic [6:0] d,
                               input logic st, input logic r);
    if (which == 0) begin
      in_data0 = d; start0 = st; rst0 = r;
    end else begin
      in_data1 = d; start1 = st; rst1 = r;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input int which, input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s line %0d", tag, i), which == 0 ? so0 : so1, 1);
      checkOutput($sformatf("%s busy %0d", tag, i), which == 0 ? busy0 : busy1, 0);
      checkOutput($sformatf("%s done %0d", tag, i), which == 0 ? done0 : done1, 0);
    end
  endtask

  // The caller applies the request at a negedge. Each later negedge checks
  // one frame cycle against the frame built from d and par. Inputs for the
  // next cycle are then driven: start is held, pulsed at pulse_at, or
  // dropped, and in_data changes at change_at.
  task automatic expectFrame(input int which, input string tag,
                             input logic [6:0] d, input logic par,
                             input int cpb, input int stops,
                             input bit hold_start, input int pulse_at,
                             input int change_at, input logic [6:0] new_data);
    int len, k;
    logic exp_line;
    logic [6:0] cur;
    logic st;
    len = (1 + 7 + P + stops) * cpb;
    cur = d;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      k = c / cpb;
      if (k == 0)                exp_line = 1'b0;
      else if (k <= 7)           exp_line = d[k-1];
      else if (P == 1 && k == 8) exp_line = par;
      else                       exp_line = 1'b1;
      checkOutput($sformatf("%s line c%0d", tag, c), which == 0 ? so0 : so1, exp_line);
      checkOutput($sformatf("%s busy c%0d", tag, c), which == 0 ? busy0 : busy1, 1);
      checkOutput($sformatf("%s done c%0d", tag, c), which == 0 ? done0 : done1,
                  (c == len - 1) ? 1 : 0);
      st = hold_start || (c == pulse_at);
      if (c == change_at) cur = new_data;
      applyStimulus(which, cur, st, 1'b0);
    end
  endtask

  initial begin
    int cnt;
    vecs[0] = '{7'b0010011, 1'b1};
    vecs[1] = '{7'h00,      1'b0};
    vecs[2] = '{7'h7F,      1'b1};
    vecs[3] = '{7'h55,      1'b0};
    vecs[4] = '{7'h2A,      1'b1};
    vecs[5] = '{7'h01,      1'b1};

    // Reset for two cycles, then idle with no request.
    applyStimulus(0, 7'h00, 1'b0, 1'b1);
    applyStimulus(1, 7'h00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    applyStimulus(0, 7'h00, 1'b0, 1'b0);
    applyStimulus(1, 7'h00, 1'b0, 1'b0);
    checkIdle(0, "rst_idle0", 5);
    checkIdle(1, "rst_idle1", 5);

    // Table-driven frames on the single-cycle instance.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(0, vecs[v].data, 1'b1, 1'b0);
      expectFrame(0, $sformatf("vec%0d", v), vecs[v].data, vecs[v].par_even,
                  1, 1, 1'b0, -1, -1, 7'h00);
      checkIdle(0, $sformatf("vec%0d_after", v), 1);
    end

    // Changing in_data at data bit 3 must not change the frame.
    applyStimulus(0, 7'b0010011, 1'b1, 1'b0);
    expectFrame(0, "chg", 7'b0010011, 1'b1, 1, 1, 1'b0, -1, 4, 7'b1111110);
    checkIdle(0, "chg_after", 2);

    // A request pulse during DATA must be ignored.
    applyStimulus(0, 7'h2A, 1'b1, 1'b0);
    expectFrame(0, "pulse", 7'h2A, 1'b1, 1, 1, 1'b0, 3, -1, 7'h00);
    checkIdle(0, "pulse_after", 3);

    // A held request gives back-to-back frames with one idle-high cycle.
    applyStimulus(0, 7'h55, 1'b1, 1'b0);
    expectFrame(0, "hold1", 7'h55, 1'b0, 1, 1, 1'b1, -1, -1, 7'h00);
    checkIdle(0, "hold_gap", 1);
    expectFrame(0, "hold2", 7'h55, 1'b0, 1, 1, 1'b0, -1, -1, 7'h00);
    checkIdle(0, "hold_after", 3);

    // Four clocks per bit, two stop bits, odd parity.
    applyStimulus(1, 7'h55, 1'b1, 1'b0);
    expectFrame(1, "cpb4", 7'h55, 1'b1, 4, 2, 1'b0, -1, -1, 7'h00);
    checkIdle(1, "cpb4_after", 2);

    // Count busy cycles for the same frame, with a bounded loop.
    applyStimulus(1, 7'h55, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1, 7'h55, 1'b0, 1'b0);
    cnt = 0;
    while (busy1 === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("cpb4_frame_len", cnt, 4 * (1 + 7 + P + 2));

    // Reset during data bit 4 aborts the frame without a done pulse.
    applyStimulus(0, 7'b0010011, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(0, 7'b0010011, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("midrst_bit4_line", so0, 1);
    checkOutput("midrst_bit4_busy", busy0, 1);
    applyStimulus(0, 7'b0010011, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("midrst_line", so0, 1);
    checkOutput("midrst_busy", busy0, 0);
    checkOutput("midrst_done", done0, 0);
    applyStimulus(0, 7'b0010011, 1'b0, 1'b0);
    checkIdle(0, "midrst_idle", 3);
    applyStimulus(0, 7'h01, 1'b1, 1'b0);
    expectFrame(0, "postrst", 7'h01, 1'b1, 1, 1, 1'b0, -1, -1, 7'h00);
    checkIdle(0, "postrst_after", 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
